// File: rtl/bash_line_endpoint.sv
// Console command endpoint: captures a command line, answers echo/help/unknown
// with NUL-terminated response lines, then hands completion back via solved/solved_ack.
module bash_line_endpoint #(
  parameter int unsigned BUFFER_LEN    = 128,
  parameter int unsigned BASH_HEAD_LEN = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_ready,
  input  logic [12:0] line_len,
  input  logic [7:0]  line_char,
  output logic        line_next,
  output logic        tx_ready,
  output logic [7:0]  tx_char,
  input  logic        tx_next,
  output logic        solved,
  input  logic        solved_ack,
  output logic        busy
);

  localparam int unsigned AW = $clog2(BUFFER_LEN);

  // Response strings are left-aligned in a 15-byte field, zero padded.
  localparam logic [119:0] StrHelp0   = {"echo <text>", 32'h0};
  localparam logic [119:0] StrHelp1   = {"help", 88'h0};
  localparam logic [119:0] StrUnknown = "Unknown command";

  typedef enum logic [2:0] {
    StIdle, StRead, StParse, StWrite, StGap, StSolve, StWaitAck
  } state_e;

  typedef enum logic [1:0] {RespNone, RespEcho, RespHelp, RespUnknown} resp_e;

  state_e      state_q, state_d;
  resp_e       resp_q, resp_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  idx_q, idx_d;
  logic        phase_q, phase_d;
  logic        line_q, line_d;
  logic        gap_q, gap_d;
  logic [7:0]  mem_q [BUFFER_LEN];

  logic [12:0]   eff_len;
  logic          capture;
  logic          is_echo, is_help;
  logic [AW-1:0] echo_idx;
  logic [7:0]    cur_len, cur_byte;
  logic          at_term;
  logic          unused_head;

  assign unused_head = ^BASH_HEAD_LEN;

  function automatic logic [7:0] str_byte(input logic [119:0] s, input logic [7:0] i);
    logic [119:0] sh;
    sh = s << {i, 3'b000};
    return sh[119:112];
  endfunction

  assign eff_len  = (line_len > 13'(BUFFER_LEN)) ? 13'(BUFFER_LEN) : line_len;
  assign echo_idx = AW'(idx_q) + AW'(5);

  assign is_echo = (count_q >= 8'd4) && (mem_q[0] == "e") && (mem_q[1] == "c") &&
                   (mem_q[2] == "h") && (mem_q[3] == "o") &&
                   ((count_q == 8'd4) || (mem_q[4] == " "));
  assign is_help = (count_q == 8'd4) && (mem_q[0] == "h") && (mem_q[1] == "e") &&
                   (mem_q[2] == "l") && (mem_q[3] == "p");

  always_comb begin
    cur_len  = 8'd0;
    cur_byte = 8'd0;
    case (resp_q)
      RespEcho: begin
        cur_len  = (count_q > 8'd5) ? count_q - 8'd5 : 8'd0;
        cur_byte = mem_q[echo_idx];
      end
      RespHelp: begin
        cur_len  = line_q ? 8'd4 : 8'd11;
        cur_byte = str_byte(line_q ? StrHelp1 : StrHelp0, idx_q);
      end
      RespUnknown: begin
        cur_len  = 8'd15;
        cur_byte = str_byte(StrUnknown, idx_q);
      end
      default: ;
    endcase
  end

  assign at_term = (idx_q == cur_len);

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    count_d = count_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    line_d  = line_q;
    gap_d   = gap_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (line_ready) begin
          state_d = StRead;
          count_d = 8'd0;
          phase_d = 1'b0;
        end
      end
      StRead: begin
        // Capture cycle pulses line_next; the following cycle only advances the count.
        if (phase_q) begin
          phase_d = 1'b0;
          count_d = count_q + 8'd1;
        end else if (!line_ready) begin
          state_d = StParse;
        end else if ({5'd0, count_q} < eff_len) begin
          capture = 1'b1;
          phase_d = 1'b1;
        end
      end
      StParse: begin
        idx_d  = 8'd0;
        line_d = 1'b0;
        if (count_q == 8'd0) begin
          resp_d  = RespNone;
          state_d = StSolve;
        end else begin
          resp_d  = is_echo ? RespEcho : (is_help ? RespHelp : RespUnknown);
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (tx_next) begin
          if (at_term) begin
            state_d = StGap;
            gap_d   = 1'b0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StGap: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else if ((resp_q == RespHelp) && !line_q) begin
          state_d = StWrite;
          line_d  = 1'b1;
          idx_d   = 8'd0;
        end else begin
          state_d = StSolve;
        end
      end
      StSolve:   state_d = StWaitAck;
      StWaitAck: if (solved_ack) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      resp_q  <= RespNone;
      count_q <= 8'd0;
      idx_q   <= 8'd0;
      phase_q <= 1'b0;
      line_q  <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      line_q  <= line_d;
      gap_q   <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      mem_q[count_q[AW-1:0]] <= line_char;
    end
  end

  // Outputs are forced low for the whole time rst is high, including its first cycle.
  assign line_next = !rst && capture;
  assign tx_ready  = !rst && (state_q == StWrite);
  assign tx_char   = tx_ready ? (at_term ? 8'h00 : cur_byte) : 8'h00;
  assign solved    = !rst && (state_q == StSolve);
  assign busy      = !rst && (state_q != StIdle);

endmodule

// File: tb/tb_bash_line_endpoint.sv
// Directed bench for bash_line_endpoint: console driver, response model built from
// the command text, and a per-cycle monitor comparing the DUT against that model.
module tb_bash_line_endpoint;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_ready;
  logic [12:0] line_len;
  logic [7:0]  line_char;
  logic        line_next;
  logic        tx_ready;
  logic [7:0]  tx_char;
  logic        tx_next;
  logic        solved;
  logic        solved_ack;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cmd_id = 0;

  logic [7:0] exp_q[$];
  logic [7:0] con_bytes [256];
  logic [8:0] con_idx;

  int mon_seen = 0;
  int mon_ptr = 0;
  int mon_solved = 0;
  int mon_txr = 0;
  int mon_low = 0;
  int mon_gaps = 0;
  logic mon_prev_ln = 1'b0;

  int last_drop_cyc;
  int last_solved_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign line_char = con_bytes[con_idx[7:0]];

  bash_line_endpoint dut (
    .clk        (clk),
    .rst        (rst),
    .line_ready (line_ready),
    .line_len   (line_len),
    .line_char  (line_char),
    .line_next  (line_next),
    .tx_ready   (tx_ready),
    .tx_char    (tx_char),
    .tx_next    (tx_next),
    .solved     (solved),
    .solved_ack (solved_ack),
    .busy       (busy)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  // Expected response bytes straight from the command semantics.
  function automatic void build_expect(input string cmd, input int cap);
    exp_q.delete();
    if (cap == 0) return;
    if (cap >= 4 && cmd.substr(0, 3) == "echo" && (cap == 4 || cmd[4] == " ")) begin
      for (int i = 5; i < cap; i++) exp_q.push_back(cmd[i]);
      exp_q.push_back(8'h00);
    end else if (cap == 4 && cmd.substr(0, 3) == "help") begin
      push_str("echo <text>");
      exp_q.push_back(8'h00);
      push_str("help");
      exp_q.push_back(8'h00);
    end else begin
      push_str("Unknown command");
      exp_q.push_back(8'h00);
    end
  endfunction

  always @(negedge clk) begin
    if (cmd_id != mon_seen) begin
      mon_seen   = cmd_id;
      mon_ptr    = 0;
      mon_solved = 0;
      mon_txr    = 0;
      mon_low    = 0;
      mon_gaps   = 0;
    end
    if (rst) check("reset_outputs", int'({line_next, tx_ready, tx_char, solved, busy}), 0);
    if (mon_prev_ln) check("line_next_low_after_pulse", int'(line_next), 0);
    mon_prev_ln = line_next;
    if (tx_ready) begin
      mon_txr++;
      if (mon_low > 0) begin
        mon_gaps++;
        check("gap_between_lines", mon_low, 2);
        mon_low = 0;
      end
      check("tx_byte_in_range", int'(mon_ptr < exp_q.size()), 1);
      if (mon_ptr < exp_q.size()) check("tx_char", int'(tx_char), int'(exp_q[mon_ptr]));
      if (tx_next) mon_ptr++;
    end else if (mon_ptr > 0 && mon_ptr < exp_q.size()) begin
      mon_low++;
    end
    if (solved) mon_solved++;
  end

  task automatic run_cmd(input string cmd, input int len, input int hold, input int stall_at,
                         input int stall_n, input int rst_at, input int exp_pulses,
                         input int exp_solved);
    int cap, pulses, tx_pos, stall_cnt, held, rst_cnt;
    bit ln_seen, dropped, done, acked, aborted;
    cap = (len > 128) ? 128 : len;
    pulses = 0; tx_pos = 0; stall_cnt = 0; held = 0; rst_cnt = 0;
    ln_seen = 0; dropped = 0; done = 0; acked = 0; aborted = 0;
    last_drop_cyc = -1;
    last_solved_cyc = -1;
    build_expect(cmd, cap);
    for (int i = 0; i < 256; i++) con_bytes[i] = (i < cmd.len()) ? cmd[i] : 8'h00;
    con_idx  = 9'd0;
    line_len = 13'(len);
    cmd_id++;
    for (int b = 0; b < 3000 && !done; b++) begin
      @(posedge clk);
      #1;
      if (ln_seen) con_idx = con_idx + 9'd1;
      if (!dropped) begin
        if ((len == 0) ? (held >= hold) : (pulses >= cap)) begin
          line_ready = 1'b0;
          dropped = 1;
          last_drop_cyc = cyc;
        end else begin
          line_ready = 1'b1;
          held++;
        end
      end
      tx_next = 1'b1;
      if (aborted) begin
        tx_next = 1'b0;
        rst_cnt++;
        if (rst_cnt == 1)
          check("outputs_after_reset", int'({line_next, tx_ready, tx_char, solved, busy}), 0);
        if (rst_cnt == 3) rst = 1'b0;
        if (rst_cnt == 8) done = 1;
      end else if (tx_ready) begin
        if (tx_pos == rst_at) begin
          rst = 1'b1;
          aborted = 1;
          tx_next = 1'b0;
        end else if (tx_pos == stall_at && stall_cnt < stall_n) begin
          tx_next = 1'b0;
          stall_cnt++;
          check("stall_holds_k", int'(tx_char), int'(8'h6b));
        end else begin
          tx_pos++;
        end
      end
      solved_ack = 1'b0;
      if (acked) done = 1;
      else if (last_solved_cyc >= 0 && cyc == last_solved_cyc + 3) begin
        solved_ack = 1'b1;
        acked = 1;
      end
      @(negedge clk);
      ln_seen = line_next;
      if (line_next) pulses++;
      if (solved && last_solved_cyc < 0) last_solved_cyc = cyc;
    end
    check("cmd_completed", int'(done), 1);
    check("line_next_pulses", pulses, exp_pulses);
    check("solved_pulses", mon_solved, exp_solved);
    if (!aborted) begin
      check("tx_bytes_consumed", mon_ptr, exp_q.size());
      check("idle_after_ack", int'(busy), 0);
    end
    tx_next = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  string long_cmd;

  initial begin
    rst = 1'b1;
    line_ready = 1'b0;
    line_len = 13'd0;
    tx_next = 1'b0;
    solved_ack = 1'b0;
    con_idx = 9'd0;
    for (int i = 0; i < 256; i++) con_bytes[i] = 8'h00;

    // Pin the model with hand-derived values.
    build_expect("echo hi", 7);
    check("model_echo_size", exp_q.size(), 3);
    check("model_echo_b0", int'(exp_q[0]), int'(8'h68));
    check("model_echo_b1", int'(exp_q[1]), int'(8'h69));
    build_expect("help", 4);
    check("model_help_size", exp_q.size(), 17);
    check("model_help_term0", int'(exp_q[11]), 0);
    build_expect("xyz", 3);
    check("model_unknown_size", exp_q.size(), 16);
    check("model_unknown_k", int'(exp_q[2]), int'(8'h6b));
    exp_q.delete();

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_tx_ready", int'(tx_ready), 0);

    run_cmd("echo hi", 7, 0, -1, 0, -1, 7, 1);

    run_cmd("", 0, 1, -1, 0, -1, 0, 1);
    check("len0_tx_ready_cycles", mon_txr, 0);
    check("len0_solved_delay", last_solved_cyc - last_drop_cyc, 2);

    run_cmd("help", 4, 0, -1, 0, -1, 4, 1);
    check("help_gap_count", mon_gaps, 1);

    run_cmd("xyz", 3, 0, 2, 5, -1, 3, 1);

    long_cmd = "";
    for (int i = 0; i < 200; i++) long_cmd = {long_cmd, "q"};
    run_cmd(long_cmd, 200, 0, -1, 0, -1, 128, 1);

    run_cmd("xyz", 3, 0, -1, 0, 3, 3, 0);
    run_cmd("echo", 4, 0, -1, 0, -1, 4, 1);
    check("echo4_tx_cycles", mon_txr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bash_line_endpoint.md
BASH_LINE_ENDPOINT -- requirements
Module: bash_line_endpoint

Interface
REQ-001 Parameter BUFFER_LEN, default 128, capacity of the command capture buffer in bytes.
REQ-002 Parameter BASH_HEAD_LEN, default 9, kept for console alignment and unused by the logic.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 line_ready  in  1  console has a command line pending; high for the whole read.
REQ-006 line_len  in  13  command length in bytes, valid while line_ready.
REQ-007 line_char  in  8  byte at the console's current read index.
REQ-008 line_next  out  1  one-cycle pulse that consumes line_char and advances the console index.
REQ-009 tx_ready  out  1  response byte valid on tx_char.
REQ-010 tx_char  out  8  response byte; 8'h00 terminates a response line.
REQ-011 tx_next  in  1  one-cycle pulse from the console meaning tx_char was consumed.
REQ-012 solved  out  1  one-cycle pulse meaning the command is finished.
REQ-013 solved_ack  in  1  one-cycle pulse from the console confirming solved.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM states SHALL be IDLE, READ, PARSE, WRITE, GAP, SOLVE and WAIT_ACK.
REQ-016 IDLE->READ occurs when line_ready=1; the read count (8 bit) is cleared on entry.
REQ-017 Effective length SHALL be min(line_len, BUFFER_LEN).
REQ-018 READ captures bytes at a two-cycle cadence:
  - On a cycle with line_next=0 and count < effective length: store line_char at buf[count] and assert line_next for that cycle.
  - On the following cycle: line_next=0, no capture, count increments.
REQ-019 READ->PARSE occurs when count equals the effective length and line_ready=0; a zero-length line captures nothing.
REQ-020 PARSE SHALL take exactly one cycle and select a response.
  - Length 0: no response lines; go to SOLVE.
  - buf[0..3]="echo" and (length=4 or buf[4]=" "): one line made of bytes 5..length-1 (empty when length is 4 or 5).
  - Exactly "help" (length 4): two lines, "echo <text>" then "help".
  - Anything else: one line, "Unknown command" (15 bytes).
REQ-021 WRITE holds tx_ready=1 with tx_char equal to the current byte.
  - On tx_next=1 the next byte is presented in the following cycle.
  - The 8'h00 terminator is the last byte of every line.
REQ-022 When tx_next consumes a terminator, tx_ready SHALL be 0 from the next cycle.
  - The FSM goes to GAP, holding tx_ready=0 for exactly 2 cycles.
  - GAP then returns to WRITE if another line remains, otherwise goes to SOLVE.
REQ-023 tx_next received while tx_ready=0 SHALL be ignored.
REQ-024 SOLVE asserts solved for exactly one cycle, then goes to WAIT_ACK.
REQ-025 WAIT_ACK->IDLE occurs on solved_ack=1; solved is not re-asserted while waiting.
REQ-026 line_ready changes outside IDLE and READ SHALL be ignored.
  - A new command is accepted only after returning to IDLE.
REQ-027 Simultaneous tx_next and terminator handling SHALL follow REQ-022; there is no skipped byte and no duplicated byte.
REQ-028 If line_ready falls during READ before count reaches the effective length, the FSM SHALL go to PARSE with the bytes captured so far.

Reset
REQ-029 While rst=1 the outputs SHALL be: line_next=0, tx_ready=0, tx_char=0, solved=0, busy=0.
REQ-030 On reset the state becomes IDLE and all counters clear; buffer contents are not reset.
REQ-031 rst asserted mid-READ or mid-WRITE SHALL abort the operation with no further pulses on line_next or solved.

Verification
REQ-032 Command "echo hi" (len 7):
  - Exactly 7 line_next pulses, each followed by one low cycle.
  - tx_char sequence 'h','i',00.
  - One solved pulse; IDLE after solved_ack.
REQ-033 Length 0 with line_ready held 1 cycle:
  - Zero line_next pulses and zero tx_ready cycles.
  - solved pulses 2 cycles after line_ready falls.
REQ-034 Command "help":
  - Output lines "echo <text>",00 and then "help",00.
  - tx_ready is low for exactly 2 cycles between the two lines.
REQ-035 Command "xyz":
  - Output "Unknown command",00.
  - The console withholds tx_next for 5 cycles on byte 3; tx_char holds 'k' stable throughout.
REQ-036 line_len=200:
  - Exactly 128 line_next pulses, then the line is parsed as unknown.
REQ-037 rst=1 asserted during byte 4 of a WRITE:
  - All outputs are 0 on the next cycle.
  - No solved pulse is produced.
  - A following "echo" (len 4) outputs only 00.
